hazard_ctrl: RTL

- Parametrised successor to the pipeline's load-use detector for the 5-stage MIPS core.
- Adds three things:
  - branch-operand hazards for branches resolved in ID;
  - a multi-cycle mul/div busy interlock;
  - EX-stage and ID-comparator forwarding selects.
- Issues IF/ID flush on taken branch/jump and keeps a saturating stall counter.
- Sits beside the IF/ID and ID/EX pipeline registers, driving PC, IF/ID and ID/EX controls and the forwarding muxes.

---
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/hazard_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline/hazard-unit signal bundle for hazard_ctrl
// master = pipeline datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
   parameter int AW    = 5,
   parameter int CNT_W = 16
);
   logic [AW-1:0]    rs_id, rt_id;
   logic             uses_rs_id, uses_rt_id;
   logic             branch_id, taken_id, jump_id;
   logic [AW-1:0]    rs_ex, rt_ex, rd_ex;
   logic             regwrite_ex, memread_ex;
   logic [AW-1:0]    rd_mem;
   logic             regwrite_mem, memread_mem;
   logic [AW-1:0]    rd_wb;
   logic             regwrite_wb;
   logic             md_start_id, md_use_id;

   logic             pc_write, ifid_write, idex_bubble, ifid_flush;
   logic [2:0]       stall_cause;
   logic [1:0]       fwd_a, fwd_b;
   logic             fwd_br_a, fwd_br_b;
   logic             md_busy;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output rs_id, rt_id, uses_rs_id, uses_rt_id, branch_id, taken_id, jump_id,
             rs_ex, rt_ex, rd_ex, regwrite_ex, memread_ex, rd_mem, regwrite_mem,
             memread_mem, rd_wb, regwrite_wb, md_start_id, md_use_id,
      input  pc_write, ifid_write, idex_bubble, ifid_flush, stall_cause,
             fwd_a, fwd_b, fwd_br_a, fwd_br_b, md_busy, stall_count
   );

   modport slave (
      input  rs_id, rt_id, uses_rs_id, uses_rt_id, branch_id, taken_id, jump_id,
             rs_ex, rt_ex, rd_ex, regwrite_ex, memread_ex, rd_mem, regwrite_mem,
             memread_mem, rd_wb, regwrite_wb, md_start_id, md_use_id,
      output pc_write, ifid_write, idex_bubble, ifid_flush, stall_cause,
             fwd_a, fwd_b, fwd_br_a, fwd_br_b, md_busy, stall_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage MIPS hazard unit: stalls, flush, forwarding selects
// Mul/div busy interlock is built only when HAZ_MULDIV_EN is defined.
module hazard_ctrl #(
   parameter int AW     = 5,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  bus
);
   localparam logic [AW-1:0] R0 = '0;

   function automatic logic hit(input logic [AW-1:0] r, input logic [AW-1:0] s, input logic u);
      return u && (r == s) && (r != R0);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                          input logic [AW-1:0] rd_m, input logic wr_m,
                                          input logic [AW-1:0] rd_w, input logic wr_w);
      if (wr_m && rd_m != R0 && rd_m == src)      return 2'b10;
      else if (wr_w && rd_w != R0 && rd_w == src) return 2'b01;
      else                                        return 2'b00;
   endfunction

   logic             ex_rs, ex_rt, mem_rs, mem_rt;
   logic             load_use, branch_dep, md_hazard, stall;
   logic             br_fwd_ok;
   logic [CNT_W-1:0] stall_cnt;

   assign ex_rs  = hit(bus.rd_ex,  bus.rs_id, bus.uses_rs_id);
   assign ex_rt  = hit(bus.rd_ex,  bus.rt_id, bus.uses_rt_id);
   assign mem_rs = hit(bus.rd_mem, bus.rs_id, bus.uses_rs_id);
   assign mem_rt = hit(bus.rd_mem, bus.rt_id, bus.uses_rt_id);

   assign load_use   = bus.memread_ex && (ex_rs || ex_rt);
   // A load in MEM still cannot feed the ID comparator, so it holds the branch a second cycle.
   assign branch_dep = bus.branch_id &&
                       ((bus.regwrite_ex && (ex_rs || ex_rt)) ||
                        (bus.memread_mem && (mem_rs || mem_rt)));
   assign stall      = !rst && (load_use || branch_dep || md_hazard);

`ifdef HAZ_MULDIV_EN
   localparam int MDW = $clog2(MD_LAT + 1);

   typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} md_state_t;

   md_state_t      md_state, md_state_nxt;
   logic [MDW-1:0] md_cnt, md_cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         md_state <= RUN;
         md_cnt   <= '0;
      end else begin
         md_state <= md_state_nxt;
         md_cnt   <= md_cnt_nxt;
      end
   end

   // A stalled mult is not accepted; it retries once the interlock clears.
   always_comb begin
      md_cnt_nxt = md_cnt;
      if (bus.md_start_id && !stall)
         md_cnt_nxt = MDW'(MD_LAT);
      else if (md_state == MD_BUSY)
         md_cnt_nxt = md_cnt - MDW'(1);
      md_state_nxt = (md_cnt_nxt != '0) ? MD_BUSY : RUN;
   end

   assign md_hazard   = (md_state == MD_BUSY) && (bus.md_use_id || bus.md_start_id);
   assign bus.md_busy = (md_state == MD_BUSY);
`else
   logic unused_md;
   assign unused_md   = &{1'b0, bus.md_start_id, bus.md_use_id, MD_LAT[0]};
   assign md_hazard   = 1'b0;
   assign bus.md_busy = 1'b0;
`endif

   assign br_fwd_ok = bus.branch_id && bus.regwrite_mem && !bus.memread_mem && (bus.rd_mem != R0);

   always_comb begin
      bus.pc_write    = 1'b1;
      bus.ifid_write  = 1'b1;
      bus.idex_bubble = 1'b0;
      bus.ifid_flush  = 1'b0;
      bus.stall_cause = 3'b000;
      bus.fwd_a       = 2'b00;
      bus.fwd_b       = 2'b00;
      bus.fwd_br_a    = 1'b0;
      bus.fwd_br_b    = 1'b0;
      if (!rst) begin
         bus.stall_cause = {md_hazard, branch_dep, load_use};
         if (stall) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_bubble = 1'b1;
         end else begin
            bus.ifid_flush  = (bus.branch_id && bus.taken_id) || bus.jump_id;
         end
         bus.fwd_a    = fwd_sel(bus.rs_ex, bus.rd_mem, bus.regwrite_mem, bus.rd_wb, bus.regwrite_wb);
         bus.fwd_b    = fwd_sel(bus.rt_ex, bus.rd_mem, bus.regwrite_mem, bus.rd_wb, bus.regwrite_wb);
         bus.fwd_br_a = br_fwd_ok && (bus.rd_mem == bus.rs_id);
         bus.fwd_br_b = br_fwd_ok && (bus.rd_mem == bus.rt_id);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall && stall_cnt != '1)
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

   assign bus.stall_count = stall_cnt;
endmodule
